// File: rtl/note_recorder.sv
// Note recorder: run-length records live key/tone codes per tick into a small buffer, then replays them.
// Optional feature: define NOTE_RECORDER_LOOP_EN to make playback wrap back to the first event.
module note_recorder #(
    parameter int DEPTH = 32,
    parameter int DUR_W = 8
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     rec,
    input  logic                     play,
    input  logic [2:0]               unable_in,
    input  logic [1:0]               tone_in,
    output logic [2:0]               unable_out,
    output logic [1:0]               tone_out,
    output logic [1:0]               state,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 5 + DUR_W;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REC  = 2'b01;
    localparam logic [1:0] ST_PLAY = 2'b10;

    localparam logic [DUR_W-1:0] DMAX      = '1;
    localparam logic [4:0]       IDLE_CODE = 5'b11100;

    logic [1:0]       state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [4:0]       pend_code_q, pend_code_d;
    logic [DUR_W-1:0] pend_dur_q,  pend_dur_d;
    logic [AW-1:0]    play_idx_q,  play_idx_d;
    logic [DUR_W-1:0] remaining_q, remaining_d;
    logic [4:0]       out_code_q,  out_code_d;

    logic [EW-1:0]    mem_q [DEPTH];

    logic             wr_en;
    logic [EW-1:0]    wr_data;
    logic             is_full;
    logic             is_last;
    logic [4:0]       sample;
    logic [AW-1:0]    next_idx;
    logic [EW-1:0]    next_event;
    logic [EW-1:0]    first_event;

    assign is_full     = (count_q == CW'(DEPTH));
    assign is_last     = ({1'b0, play_idx_q} + CW'(1)) == count_q;
    assign sample      = {unable_in, tone_in};
    assign next_idx    = play_idx_q + AW'(1);
    assign next_event  = mem_q[next_idx];
    assign first_event = mem_q[0];
    assign wr_data     = {pend_code_q, pend_dur_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_code_d = pend_code_q;
        pend_dur_d  = pend_dur_q;
        play_idx_d  = play_idx_q;
        remaining_d = remaining_q;
        out_code_d  = out_code_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_code_d = IDLE_CODE;
                if (rec) begin
                    state_d    = ST_REC;
                    count_d    = '0;
                    pend_dur_d = '0;
                end else if (play && (count_q != '0)) begin
                    state_d     = ST_PLAY;
                    play_idx_d  = '0;
                    out_code_d  = first_event[EW-1 -: 5];
                    remaining_d = first_event[DUR_W-1:0];
                end
            end

            ST_REC: begin
                out_code_d = IDLE_CODE;
                if (!rec) begin
                    // Flush the event still being accumulated on the way out.
                    state_d = ST_IDLE;
                    if ((pend_dur_q != '0) && !is_full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    pend_dur_d = '0;
                end else if (tick) begin
                    if (pend_dur_q == '0) begin
                        pend_code_d = sample;
                        pend_dur_d  = DUR_W'(1);
                    end else if ((sample == pend_code_q) && (pend_dur_q < DMAX)) begin
                        pend_dur_d = pend_dur_q + DUR_W'(1);
                    end else begin
                        if (!is_full) begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                        pend_code_d = sample;
                        pend_dur_d  = DUR_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (!play || rec) begin
                    state_d     = ST_IDLE;
                    out_code_d  = IDLE_CODE;
                    remaining_d = '0;
                end else if (tick) begin
                    if (remaining_q > DUR_W'(1)) begin
                        remaining_d = remaining_q - DUR_W'(1);
                    end else if (!is_last) begin
                        play_idx_d  = next_idx;
                        out_code_d  = next_event[EW-1 -: 5];
                        remaining_d = next_event[DUR_W-1:0];
                    end else begin
`ifdef NOTE_RECORDER_LOOP_EN
                        play_idx_d  = '0;
                        out_code_d  = first_event[EW-1 -: 5];
                        remaining_d = first_event[DUR_W-1:0];
`else
                        state_d     = ST_IDLE;
                        out_code_d  = IDLE_CODE;
                        remaining_d = '0;
`endif
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_code_d  = IDLE_CODE;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pend_code_q <= '0;
            pend_dur_q  <= '0;
            play_idx_q  <= '0;
            remaining_q <= '0;
            out_code_q  <= IDLE_CODE;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_code_q <= pend_code_d;
            pend_dur_q  <= pend_dur_d;
            play_idx_q  <= play_idx_d;
            remaining_q <= remaining_d;
            out_code_q  <= out_code_d;
        end
    end

    // The event buffer carries no reset; count alone decides which entries are valid.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= wr_data;
        end
    end

    assign unable_out = out_code_q[4:2];
    assign tone_out   = out_code_q[1:0];
    assign state      = state_q;
    assign full       = is_full;
    assign count      = count_q;

endmodule

// File: tb/tb_note_recorder.sv
// Randomized scoreboard bench for note_recorder: a run-length model predicts the stored events
// and the replayed per-tick code stream, which a negedge monitor checks during playback.
module tb_note_recorder;

    localparam int DEPTH = 8;
    localparam int DUR_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DMAX  = (1 << DUR_W) - 1;

    logic          sysclk;
    logic          rst;
    logic          tick;
    logic          rec;
    logic          play;
    logic [2:0]    unable_in;
    logic [1:0]    tone_in;
    logic [2:0]    unable_out;
    logic [1:0]    tone_out;
    logic [1:0]    state;
    logic          full;
    logic [CW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int raw_events  = 0;

    logic [4:0] exp_q[$];
    logic [4:0] stim_codes[$];
    logic [4:0] ev_code[$];
    int         ev_dur[$];
    logic [4:0] mon_exp;

    note_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .tick       (tick),
        .rec        (rec),
        .play       (play),
        .unable_in  (unable_in),
        .tone_in    (tone_in),
        .unable_out (unable_out),
        .tone_out   (tone_out),
        .state      (state),
        .full       (full),
        .count      (count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic r, input logic p, input logic [4:0] code);
        @(posedge sysclk);
        #1;
        tick      = t;
        rec       = r;
        play      = p;
        unable_in = code[4:2];
        tone_in   = code[1:0];
    endtask

    function automatic logic [4:0] rand_code();
        logic [4:0] c;
        c = 5'($urandom_range(0, 31));
        return c;
    endfunction

    // Run-length encode the ticked samples, capping each run at DMAX, and keep the first DEPTH.
    task automatic modelEvents();
        ev_code.delete();
        ev_dur.delete();
        foreach (stim_codes[i]) begin
            if (ev_code.size() > 0 && ev_code[ev_code.size()-1] == stim_codes[i]
                && ev_dur[ev_dur.size()-1] < DMAX) begin
                ev_dur[ev_dur.size()-1] = ev_dur[ev_dur.size()-1] + 1;
            end else begin
                ev_code.push_back(stim_codes[i]);
                ev_dur.push_back(1);
            end
        end
        raw_events = ev_code.size();
        while (ev_code.size() > DEPTH) begin
            void'(ev_code.pop_back());
            void'(ev_dur.pop_back());
        end
    endtask

    task automatic fillExpected();
        exp_q.delete();
        foreach (ev_code[i]) begin
            repeat (ev_dur[i]) exp_q.push_back(ev_code[i]);
        end
    endtask

    task automatic recordSession();
        int pre;
        applyStimulus(1'b0, 1'b1, 1'b0, rand_code());
        foreach (stim_codes[i]) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b1, 1'b0, rand_code());
            applyStimulus(1'b1, 1'b1, 1'b0, stim_codes[i]);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, rand_code());
        modelEvents();
        if (raw_events == 0) pre = 0;
        else pre = (raw_events - 1 < DEPTH) ? raw_events - 1 : DEPTH;
        checkOutput("rec_state_held", state, 2'b01);
        checkOutput("rec_count_pre_exit", count, pre);
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        checkOutput("rec_exit_state", state, 2'b00);
        checkOutput("rec_count", count, ev_code.size());
        checkOutput("rec_full", full, ev_code.size() == DEPTH);
        checkOutput("idle_out", {unable_out, tone_out}, 5'b11100);
    endtask

    task automatic playSession();
        int budget;
        budget = 3000;
        fillExpected();
        applyStimulus(1'b0, 1'b0, 1'b1, rand_code());
        while (1) begin
            @(posedge sysclk);
            #1;
            if (exp_q.size() == 0 || budget == 0) break;
            tick = ($urandom_range(0, 2) != 0);
            play = 1'b1;
            budget--;
        end
        tick = 1'b0;
        checkOutput("play_drained", exp_q.size(), 0);
`ifdef NOTE_RECORDER_LOOP_EN
        checkOutput("loop_state", state, 2'b10);
        checkOutput("loop_reload", {unable_out, tone_out}, ev_code[0]);
        play = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        checkOutput("loop_stop_state", state, 2'b00);
`else
        play = 1'b0;
        checkOutput("play_end_state", state, 2'b00);
        checkOutput("play_end_out", {unable_out, tone_out}, 5'b11100);
`endif
        exp_q.delete();
    endtask

    task automatic genRandom(input int n);
        logic [4:0] c;
        stim_codes.delete();
        c = rand_code();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 3) c = rand_code();
            stim_codes.push_back(c);
        end
    endtask

    // Scoreboard monitor: every ticked cycle in PLAY presents one replayed code.
    always @(negedge sysclk) begin
        if (rst === 1'b1 && state === 2'b10 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL play_extra: got code %b on a tick, required no further ticks in PLAY",
                         {unable_out, tone_out});
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("play_code", {unable_out, tone_out}, mon_exp);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        tick      = 1'b0;
        rec       = 1'b0;
        play      = 1'b0;
        unable_in = 3'b111;
        tone_in   = 2'b00;
        #23;
        checkOutput("reset_state", state, 2'b00);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_full", full, 1'b0);
        checkOutput("reset_out", {unable_out, tone_out}, 5'b11100);
        #4 rst = 1'b1;

        // Two-event recording and its exact-duration replay.
        stim_codes.delete();
        repeat (5) stim_codes.push_back(5'b010_01);
        repeat (2) stim_codes.push_back(5'b111_01);
        recordSession();
        checkOutput("two_event_count", count, 2);
        playSession();

        // Long constant key saturates the duration field.
        stim_codes.delete();
        repeat (40) stim_codes.push_back(5'b011_10);
        recordSession();
        checkOutput("saturate_count", count, 3);
        playSession();

        // Alternating keys overflow the buffer.
        stim_codes.delete();
        for (int i = 0; i < 12; i++) stim_codes.push_back((i % 2 == 0) ? 5'b001_00 : 5'b100_11);
        recordSession();
        checkOutput("overflow_full", full, 1'b1);
        playSession();

        for (int s = 0; s < 5; s++) begin
            genRandom($urandom_range(10, 40));
            recordSession();
            playSession();
        end

        // Abort playback partway through a 5-tick event.
        stim_codes.delete();
        repeat (5) stim_codes.push_back(5'b101_01);
        recordSession();
        fillExpected();
        applyStimulus(1'b0, 1'b0, 1'b1, rand_code());
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, rand_code());
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        checkOutput("abort_state", state, 2'b00);
        checkOutput("abort_out", {unable_out, tone_out}, 5'b11100);
        checkOutput("abort_count", count, 1);
        exp_q.delete();

        // Asynchronous reset in the middle of playback.
        genRandom(20);
        recordSession();
        fillExpected();
        applyStimulus(1'b0, 1'b0, 1'b1, rand_code());
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, rand_code());
        @(posedge sysclk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_state", state, 2'b00);
        checkOutput("async_rst_out", {unable_out, tone_out}, 5'b11100);
        checkOutput("async_rst_count", count, 0);
        checkOutput("async_rst_full", full, 1'b0);
        exp_q.delete();
        tick = 1'b0;
        play = 1'b0;
        #3 rst = 1'b1;

        applyStimulus(1'b0, 1'b1, 1'b1, rand_code());
        applyStimulus(1'b0, 1'b1, 1'b1, rand_code());
        checkOutput("rec_priority_state", state, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());
        checkOutput("empty_rec_count", count, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, rand_code());
        applyStimulus(1'b0, 1'b0, 1'b1, rand_code());
        checkOutput("play_empty_state", state, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, rand_code());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
